// File: rtl/qracc_sram_ctrl.sv
// SRAM request controller for the QRAcc array: serialises precharge/wordline/sense per request.
// Optional write readback-verify enabled by defining QRACC_SRAM_WRITE_VERIFY_EN.
module qracc_sram_ctrl #(
  parameter int unsigned numRows   = 128,
  parameter int unsigned numCols   = 32,
  parameter int unsigned pchCycles = 1,
  parameter int unsigned wlCycles  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rq_valid_i,
  input  logic                       rq_wr_i,
  input  logic [$clog2(numRows)-1:0] addr_i,
  input  logic [numCols-1:0]         wr_data_i,
  output logic                       rq_ready_o,
  output logic                       rd_valid_o,
  output logic [numCols-1:0]         rd_data_o,
  output logic                       wr_err_o,
  output logic [numRows-1:0]         WL,
  output logic                       PCH,
  output logic                       WRITE,
  output logic [numCols-1:0]         WR_DATA,
  output logic [numCols-1:0]         CSEL,
  output logic                       SAEN,
  input  logic [numCols-1:0]         SA_OUT
);

  localparam int unsigned AW   = $clog2(numRows);
  localparam int unsigned MAXC = (pchCycles > wlCycles) ? pchCycles : wlCycles;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PCH   = 2'd1;
  localparam logic [1:0] S_WL    = 2'd2;
  localparam logic [1:0] S_SENSE = 2'd3;

  logic [1:0]         state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [AW-1:0]      addr_q, addr_nx;
  logic               wr_q, wr_nx;
  logic [numCols-1:0] data_q, data_nx;
  logic               vphase, vphase_nx;
  logic               rd_valid_nx, wr_err_nx;
  logic [numCols-1:0] rd_data_nx;
  logic               wr_phase_nx, wl_on_nx;

  // Next-state, request latching and sense capture
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    addr_nx     = addr_q;
    wr_nx       = wr_q;
    data_nx     = data_q;
    vphase_nx   = vphase;
    rd_valid_nx = 1'b0;
    wr_err_nx   = 1'b0;
    rd_data_nx  = rd_data_o;
    case (state)
      S_IDLE: begin
        if (rq_valid_i && rq_ready_o) begin
          state_nx  = S_PCH;
          cnt_nx    = CW'(pchCycles - 1);
          addr_nx   = addr_i;
          wr_nx     = rq_wr_i;
          data_nx   = wr_data_i;
          vphase_nx = 1'b0;
        end
      end
      S_PCH: begin
        if (cnt == '0) begin
          state_nx = S_WL;
          cnt_nx   = CW'(wlCycles - 1);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_WL: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (wr_q && !vphase) begin
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
          state_nx  = S_PCH;
          cnt_nx    = CW'(pchCycles - 1);
          vphase_nx = 1'b1;
`else
          state_nx = S_IDLE;
          cnt_nx   = '0;
`endif
        end else begin
          state_nx = S_SENSE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        if (!vphase) begin
          rd_valid_nx = 1'b1;
          rd_data_nx  = SA_OUT;
        end
`ifdef QRACC_SRAM_WRITE_VERIFY_EN
        wr_err_nx = vphase && (SA_OUT != data_q);
`endif
      end
    endcase
    // Analog controls are decoded from the next state so they register in step with it
    wr_phase_nx = (state_nx == S_WL) && wr_nx && !vphase_nx;
    wl_on_nx    = (state_nx == S_WL) || (state_nx == S_SENSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      vphase     <= 1'b0;
      rq_ready_o <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      wr_err_o   <= 1'b0;
      WL         <= '0;
      PCH        <= 1'b0;
      WRITE      <= 1'b0;
      WR_DATA    <= '0;
      CSEL       <= '0;
      SAEN       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      addr_q     <= addr_nx;
      wr_q       <= wr_nx;
      data_q     <= data_nx;
      vphase     <= vphase_nx;
      rq_ready_o <= (state_nx == S_IDLE);
      rd_valid_o <= rd_valid_nx;
      rd_data_o  <= rd_data_nx;
      wr_err_o   <= wr_err_nx;
      WL         <= wl_on_nx ? (numRows'(1) << addr_nx) : '0;
      PCH        <= (state_nx == S_PCH);
      WRITE      <= wr_phase_nx;
      WR_DATA    <= wr_phase_nx ? data_nx : '0;
      CSEL       <= wl_on_nx ? '1 : '0;
      SAEN       <= (state_nx == S_SENSE);
    end
  end

endmodule
